alu_result_fifo: RTL
====================

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001: clk  input  1  -- single clock; all state updates on rising edge.
REQ-002: rst  input  1  -- reset; asynchronous, active-high.
REQ-003: in_valid  input  1  -- upstream ALU result valid this cycle.
REQ-004: in_ready  output  1  -- FIFO can accept an entry; equals (count != 4).
REQ-005: in_result  input  16  -- ALU result (add/sub zero-extended, mul full product).
REQ-006: in_carry  input  1  -- ALU carry/borrow.
REQ-007: in_sel  input  2  -- ALU op code: 00 add, 01 sub, 10 mul, 11 illegal.
REQ-008: out_valid  output  1  -- head entry valid.
REQ-009: out_ready  input  1  -- downstream accepts head entry.
REQ-010: out_result  output  16; out_carry  output  1; out_op  output  2  -- head entry fields.
REQ-011: out_zero  output  1  -- head entry result == 16'h0000.
REQ-012: count  output  3  -- stored entries, 0..4.
REQ-013: illegal_op  output  1  -- sticky flag, set on any accepted-cycle with in_sel == 11.

Function
REQ-014: Storage SHALL be 4 entries of {op[1:0], carry, zero, result[15:0]}, circular, 2-bit read/write pointers wrapping 3->0.
REQ-015: Push SHALL occur when in_valid && in_ready && in_sel != 2'b11.
REQ-016: Pop SHALL occur when out_valid && out_ready.
REQ-017: zero bit SHALL be computed from in_result at push and stored; not recomputed at output.
REQ-018: in_sel == 11 with in_valid && in_ready SHALL not push, SHALL set illegal_op next edge; illegal_op clears only on rst.
REQ-019: out_valid SHALL equal (count != 0); output fields SHALL be the entry at read pointer, registered-storage driven (no combinational path from in_* to out_*) unless REQ-030 applies.
REQ-020: Latency (macro off) SHALL be 1 cycle: entry pushed at edge N is visible with out_valid=1 after edge N.
REQ-021: Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-022: Full (count==4): in_ready=0; a pop in that cycle SHALL NOT enable a push in the same cycle (in_ready derived from count only).
REQ-023: Empty: pop not possible; out_* fields are don't-care but SHALL hold last driven values (no X propagation).
REQ-024: count SHALL update +1 on push only, -1 on pop only, unchanged otherwise; never exceed 4 or drop below 0.
REQ-025: Entries SHALL be delivered in push order; no entry dropped or duplicated.

Reset
REQ-026: rst high SHALL immediately (asynchronously) force count=0, pointers=0, out_valid=0, in_ready=1, illegal_op=0, out_result=0, out_carry=0, out_zero=0, out_op=0.
REQ-027: rst asserted mid-operation SHALL discard all stored entries; first push after rst deassert lands at index 0.
REQ-028: Storage array contents need not be reset; outputs SHALL be gated so reset values of REQ-026 are seen while count==0 after reset.

Configuration
REQ-029: Macro ALU_FIFO_BYPASS_EN SHALL select empty-bypass.
REQ-030: With ALU_FIFO_BYPASS_EN defined: when count==0, out_valid=in_valid && in_sel!=11 and out_* driven combinationally from in_* (zero from in_result); if out_ready also high, entry SHALL pass through without being stored (count stays 0). Latency 0 cycles when empty.
REQ-031: Without ALU_FIFO_BYPASS_EN: no combinational in->out path; behaviour per REQ-019/020.

Verification
REQ-032: Push result=16'h0005, carry=0, sel=00, out_ready=0 -> next cycle out_valid=1, out_result=0005, out_op=00, out_zero=0, count=1.
REQ-033: Push 4 entries (0001,0002,0003,0004), out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored; then out_ready=1 for 4 cycles -> outputs 0001..0004 in order, count 0, out_valid=0.
REQ-034: count=2, push and pop same cycle for 6 cycles -> count stays 2, pointers wrap, order preserved.
REQ-035: Push sel=11 result=00FF -> no push, count=0, illegal_op=1 until rst; then push sel=01 result=0000 carry=1 -> out_zero=1, out_carry=1, out_op=01.
REQ-036: count=3, assert rst asynchronously mid-cycle -> count=0, out_valid=0, in_ready=1 before next edge; next push visible at index 0.
REQ-037: ALU_FIFO_BYPASS_EN defined, empty, in_valid=1 result=1234 sel=10 out_ready=1 -> same cycle out_valid=1, out_result=1234; after edge count=0.

Source files
------------

// File: rtl/alu_result_fifo.sv
// Four-entry result FIFO between an ALU and its consumer, with a sticky illegal-opcode flag.
// Define ALU_FIFO_BYPASS_EN to let an empty FIFO pass an entry straight through in the same cycle.
module alu_result_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_result,
    input  logic        in_carry,
    input  logic [1:0]  in_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_carry,
    output logic [1:0]  out_op,
    output logic        out_zero,
    output logic [2:0]  count,
    output logic        illegal_op
);

    localparam logic [1:0] SelIllegal = 2'b11;

    // Entry layout: {op[1:0], carry, zero, result[15:0]}
    logic [19:0] mem_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        illegal_q, illegal_d;
    logic [19:0] hold_q, hold_d;

    logic [19:0] in_entry;
    logic [19:0] head;
    logic        in_legal;
    logic        push;
    logic        pop;
    logic        bypass;

    assign in_legal = (in_sel != SelIllegal);
    assign in_entry = {in_sel, in_carry, (in_result == 16'h0000), in_result};

    always_comb begin
        in_ready  = (count_q != 3'd4);
        out_valid = (count_q != 3'd0);
        head      = out_valid ? mem_q[rd_ptr_q] : hold_q;
        bypass    = 1'b0;
`ifdef ALU_FIFO_BYPASS_EN
        if (count_q == 3'd0) begin
            out_valid = in_valid && in_legal;
            head      = in_entry;
            bypass    = out_valid && out_ready;
        end
`endif
        pop  = out_valid && out_ready && (count_q != 3'd0);
        push = in_valid && in_ready && in_legal && !bypass;

        wr_ptr_d  = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d   = count_q + 3'(push) - 3'(pop);
        illegal_d = illegal_q || (in_valid && in_ready && !in_legal);
        // Remember the last head shown so an emptied FIFO keeps driving it rather than stale RAM.
        hold_d    = (count_q != 3'd0) ? mem_q[rd_ptr_q] : hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            illegal_q <= 1'b0;
            hold_q    <= 20'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            hold_q    <= hold_d;
        end
    end

    // Storage is only read while count is non-zero, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign out_op     = head[19:18];
    assign out_carry  = head[17];
    assign out_zero   = head[16];
    assign out_result = head[15:0];
    assign count      = count_q;
    assign illegal_op = illegal_q;

endmodule
